active_list_commit: RTL and testbench

//  In-order retirement buffer at the far end of the MEM->WB register. Rename

---
 rtl/active_list_commit.sv | 159 +++++++++++++++
 tb/tb_active_list_commit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/active_list_commit.sv
// In-order retirement buffer: rename allocates at tail, writeback marks entries done,
// and the head entry retires once done, releasing its superseded physical register.
module active_list_commit #(
    parameter int FREE_LIST_WIDTH = 3,
    parameter int VREG_WIDTH      = 5,
    parameter int PREG_WIDTH      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_has_dest,
    input  logic [VREG_WIDTH-1:0]      alloc_vreg,
    input  logic [PREG_WIDTH-1:0]      alloc_preg,
    input  logic [PREG_WIDTH-1:0]      alloc_old_preg,
    output logic [FREE_LIST_WIDTH-1:0] alloc_index,
    input  logic                       wb_valid,
    input  logic [FREE_LIST_WIDTH-1:0] wb_index,
    output logic                       commit_valid,
    output logic                       commit_has_dest,
    output logic [VREG_WIDTH-1:0]      commit_vreg,
    output logic [PREG_WIDTH-1:0]      commit_preg,
    output logic                       free_valid,
    output logic [PREG_WIDTH-1:0]      free_preg,
    output logic [FREE_LIST_WIDTH:0]   count
);

    localparam int DEPTH = 2 ** FREE_LIST_WIDTH;
    localparam logic [FREE_LIST_WIDTH:0]   DEPTH_CNT = {1'b1, {FREE_LIST_WIDTH{1'b0}}};
    localparam logic [FREE_LIST_WIDTH-1:0] IDX_ONE   = {{(FREE_LIST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FREE_LIST_WIDTH:0]   CNT_ZERO  = '0;

    logic [FREE_LIST_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [FREE_LIST_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]           valid_q, valid_d, done_q, done_d, has_dest_q, has_dest_d;
    logic [VREG_WIDTH-1:0]      vreg_q [DEPTH];
    logic [VREG_WIDTH-1:0]      vreg_d [DEPTH];
    logic [PREG_WIDTH-1:0]      preg_q [DEPTH];
    logic [PREG_WIDTH-1:0]      preg_d [DEPTH];
    logic [PREG_WIDTH-1:0]      old_preg_q [DEPTH];
    logic [PREG_WIDTH-1:0]      old_preg_d [DEPTH];

    logic                       commit_valid_q, commit_valid_d;
    logic                       commit_has_dest_q, commit_has_dest_d;
    logic [VREG_WIDTH-1:0]      commit_vreg_q, commit_vreg_d;
    logic [PREG_WIDTH-1:0]      commit_preg_q, commit_preg_d;
    logic                       free_valid_q, free_valid_d;
    logic [PREG_WIDTH-1:0]      free_preg_q, free_preg_d;

    logic alloc_fire, commit_fire;

    // Readiness looks only at the registered count, so a full list never
    // accepts an allocation in the same cycle it retires an entry.
    assign alloc_ready = (count_q < DEPTH_CNT);
    assign alloc_index = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = valid_q[head_q] && done_q[head_q];

    always_comb begin
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        valid_d           = valid_q;
        done_d            = done_q;
        has_dest_d        = has_dest_q;
        vreg_d            = vreg_q;
        preg_d            = preg_q;
        old_preg_d        = old_preg_q;
        commit_valid_d    = 1'b0;
        commit_has_dest_d = commit_has_dest_q;
        commit_vreg_d     = commit_vreg_q;
        commit_preg_d     = commit_preg_q;
        free_valid_d      = 1'b0;
        free_preg_d       = free_preg_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_ZERO;
        end else begin
            if (wb_valid && valid_q[wb_index]) begin
                done_d[wb_index] = 1'b1;
            end
            if (commit_fire) begin
                commit_valid_d    = 1'b1;
                commit_has_dest_d = has_dest_q[head_q];
                commit_vreg_d     = vreg_q[head_q];
                commit_preg_d     = preg_q[head_q];
                free_valid_d      = has_dest_q[head_q];
                free_preg_d       = old_preg_q[head_q];
                valid_d[head_q]   = 1'b0;
                done_d[head_q]    = 1'b0;
                head_d            = head_q + IDX_ONE;
            end
            // Allocation comes last so it wins over a same-index writeback.
            if (alloc_fire) begin
                valid_d[tail_q]    = 1'b1;
                done_d[tail_q]     = 1'b0;
                has_dest_d[tail_q] = alloc_has_dest;
                vreg_d[tail_q]     = alloc_vreg;
                preg_d[tail_q]     = alloc_preg;
                old_preg_d[tail_q] = alloc_old_preg;
                tail_d             = tail_q + IDX_ONE;
            end
            count_d = count_q + {{FREE_LIST_WIDTH{1'b0}}, alloc_fire}
                              - {{FREE_LIST_WIDTH{1'b0}}, commit_fire};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            valid_q           <= '0;
            done_q            <= '0;
            has_dest_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vreg_q[i]     <= '0;
                preg_q[i]     <= '0;
                old_preg_q[i] <= '0;
            end
            commit_valid_q    <= 1'b0;
            commit_has_dest_q <= 1'b0;
            commit_vreg_q     <= '0;
            commit_preg_q     <= '0;
            free_valid_q      <= 1'b0;
            free_preg_q       <= '0;
        end else begin
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            valid_q           <= valid_d;
            done_q            <= done_d;
            has_dest_q        <= has_dest_d;
            vreg_q            <= vreg_d;
            preg_q            <= preg_d;
            old_preg_q        <= old_preg_d;
            commit_valid_q    <= commit_valid_d;
            commit_has_dest_q <= commit_has_dest_d;
            commit_vreg_q     <= commit_vreg_d;
            commit_preg_q     <= commit_preg_d;
            free_valid_q      <= free_valid_d;
            free_preg_q       <= free_preg_d;
        end
    end

    assign commit_valid    = commit_valid_q;
    assign commit_has_dest = commit_has_dest_q;
    assign commit_vreg     = commit_vreg_q;
    assign commit_preg     = commit_preg_q;
    assign free_valid      = free_valid_q;
    assign free_preg       = free_preg_q;
    assign count           = count_q;

endmodule

// File: tb/tb_active_list_commit.sv
// Directed bench for active_list_commit: hand-computed expectations for reset,
// retirement order, full/wrap, no-dest entries, flush and asynchronous reset.
module tb_active_list_commit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic       alloc_has_dest = 1'b0;
    logic [4:0] alloc_vreg = '0;
    logic [5:0] alloc_preg = '0;
    logic [5:0] alloc_old_preg = '0;
    logic [2:0] alloc_index;
    logic       wb_valid = 1'b0;
    logic [2:0] wb_index = '0;
    logic       commit_valid;
    logic       commit_has_dest;
    logic [4:0] commit_vreg;
    logic [5:0] commit_preg;
    logic       free_valid;
    logic [5:0] free_preg;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    active_list_commit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_vreg(alloc_vreg),
        .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
        .alloc_index(alloc_index), .wb_valid(wb_valid), .wb_index(wb_index),
        .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
        .commit_vreg(commit_vreg), .commit_preg(commit_preg),
        .free_valid(free_valid), .free_preg(free_preg), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_alloc(input logic hd, input logic [4:0] v, input logic [5:0] p,
                            input logic [5:0] op);
        alloc_valid    = 1'b1;
        alloc_has_dest = hd;
        alloc_vreg     = v;
        alloc_preg     = p;
        alloc_old_preg = op;
        step();
        alloc_valid    = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] idx);
        wb_valid = 1'b1;
        wb_index = idx;
        step();
        wb_valid = 1'b0;
    endtask

    // Pops the oldest expected retired preg and compares against the commit bus.
    task automatic check_commit(input string tag);
        logic [5:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        check_eq({tag, "_valid"}, commit_valid, 1);
        check_eq({tag, "_preg"}, commit_preg, e);
    endtask

    initial begin
        // Test 1: reset state
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ready", alloc_ready, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_index", alloc_index, 0);
        check_eq("rst_commit", commit_valid, 0);
        check_eq("rst_free", free_valid, 0);
        step();
        rst = 1'b0;

        // Test 2: single instruction retire
        do_alloc(1'b1, 5'd3, 6'd9, 6'd3);
        check_eq("t2_count1", count, 1);
        check_eq("t2_index1", alloc_index, 1);
        do_wb(3'd0);
        check_eq("t2_no_early_commit", commit_valid, 0);
        step();
        check_eq("t2_commit", commit_valid, 1);
        check_eq("t2_vreg", commit_vreg, 3);
        check_eq("t2_preg", commit_preg, 9);
        check_eq("t2_free", free_valid, 1);
        check_eq("t2_free_preg", free_preg, 3);
        check_eq("t2_count0", count, 0);
        step();
        check_eq("t2_pulse_end", commit_valid, 0);

        // Test 3: out-of-order writeback, in-order retirement
        do_reset();
        do_alloc(1'b1, 5'd1, 6'd10, 6'd1); exp_q.push_back(6'd10);
        do_alloc(1'b1, 5'd2, 6'd11, 6'd2); exp_q.push_back(6'd11);
        do_alloc(1'b1, 5'd4, 6'd12, 6'd4); exp_q.push_back(6'd12);
        check_eq("t3_count3", count, 3);
        do_wb(3'd2);
        check_eq("t3_hold_a", commit_valid, 0);
        do_wb(3'd1);
        check_eq("t3_hold_b", commit_valid, 0);
        do_wb(3'd0);
        check_eq("t3_hold_c", commit_valid, 0);
        step(); check_commit("t3_c0");
        step(); check_commit("t3_c1");
        step(); check_commit("t3_c2");
        step();
        check_eq("t3_idle", commit_valid, 0);
        check_eq("t3_count0", count, 0);

        // Test 4: full list, ignored alloc, no bypass, wrap-around
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_alloc(1'b1, 5'(i + 1), 6'(20 + i), 6'(40 + i));
        end
        check_eq("t4_full_ready", alloc_ready, 0);
        check_eq("t4_full_count", count, 8);
        check_eq("t4_full_index", alloc_index, 0);
        do_alloc(1'b1, 5'd31, 6'd63, 6'd63);
        check_eq("t4_ignored_count", count, 8);
        do_wb(3'd0);
        step();
        check_eq("t4_commit", commit_valid, 1);
        check_eq("t4_commit_preg", commit_preg, 20);
        check_eq("t4_free_preg", free_preg, 40);
        check_eq("t4_count7", count, 7);
        check_eq("t4_ready", alloc_ready, 1);
        check_eq("t4_wrap_index", alloc_index, 0);
        do_alloc(1'b1, 5'd9, 6'd30, 6'd50);
        check_eq("t4_refull", count, 8);
        check_eq("t4_tail_wrap", alloc_index, 1);
        do_wb(3'd1);
        alloc_valid = 1'b1;
        alloc_vreg  = 5'd17;
        step();
        alloc_valid = 1'b0;
        check_eq("t4_nobypass_commit", commit_preg, 21);
        check_eq("t4_nobypass_count", count, 7);

        // Test 5: no-destination entry and writeback to unallocated index
        do_reset();
        do_alloc(1'b0, 5'd7, 6'd33, 6'd44);
        do_wb(3'd3);
        check_eq("t5_badwb_count", count, 1);
        check_eq("t5_badwb_index", alloc_index, 1);
        step();
        check_eq("t5_badwb_commit", commit_valid, 0);
        do_wb(3'd0);
        step();
        check_eq("t5_commit", commit_valid, 1);
        check_eq("t5_has_dest", commit_has_dest, 0);
        check_eq("t5_vreg", commit_vreg, 7);
        check_eq("t5_free", free_valid, 0);

        // Test 6: flush with partially done entries, then async reset mid-fill
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_alloc(1'b1, 5'(i), 6'(i + 1), 6'(i + 8));
        end
        do_wb(3'd3);
        do_wb(3'd4);
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_index = 3'd0;
        step();
        flush    = 1'b0;
        wb_valid = 1'b0;
        check_eq("t6_flush_commit", commit_valid, 0);
        check_eq("t6_flush_count", count, 0);
        check_eq("t6_flush_index", alloc_index, 0);
        step();
        check_eq("t6_flush_stays", commit_valid, 0);
        do_alloc(1'b1, 5'd5, 6'd6, 6'd7);
        do_alloc(1'b1, 5'd6, 6'd7, 6'd8);
        do_wb(3'd0);
        alloc_valid = 1'b1;
        step();
        check_eq("t6_pre_rst_commit", commit_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_arst_commit", commit_valid, 0);
        check_eq("t6_arst_free", free_valid, 0);
        check_eq("t6_arst_free_preg", free_preg, 0);
        check_eq("t6_arst_count", count, 0);
        check_eq("t6_arst_index", alloc_index, 0);
        check_eq("t6_arst_ready", alloc_ready, 1);
        alloc_valid = 1'b0;
        step();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
